// File: rtl/cordic_vec_ctrl.sv
// Vectoring-mode CORDIC stage: drives y toward zero, returns scaled magnitude and direction bits.
// Optional gain compensation stage enabled by defining CORDIC_GAIN_COMP_EN.
module cordic_vec_ctrl #(
  parameter int W     = 16,
  parameter int ITERS = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic [3:0]           cnt,
  output logic                 cnt_en,
  output logic                 busy,
  output logic                 done,
  output logic signed [W+1:0]  mag_out,
  output logic [ITERS-1:0]     dir_out,
  output logic                 flip_out
);

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ITER = 3'd2, COMP = 3'd3, DONE = 3'd4} state_t;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, PRE = 3'd1, ITER = 3'd2, DONE = 3'd4} state_t;
`endif

  localparam logic [3:0] LAST = 4'(ITERS - 1);

  state_t                state, state_n;
  logic signed [W+1:0]   xr, yr, xr_n, yr_n;
  logic signed [W+1:0]   xs, ys;
  logic [ITERS-1:0]      dir_r, dir_n;
  logic                  flip_r, flip_n;

  assign xs   = xr >>> cnt;
  assign ys   = yr >>> cnt;
  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Next-state and datapath update; every micro-rotation uses the pre-update xr/yr.
  always_comb begin
    state_n = state;
    xr_n    = xr;
    yr_n    = yr;
    dir_n   = dir_r;
    flip_n  = flip_r;
    case (state)
      IDLE: begin
        if (start) begin
          xr_n    = {{2{x_in[W-1]}}, x_in};
          yr_n    = {{2{y_in[W-1]}}, y_in};
          flip_n  = 1'b0;
          state_n = PRE;
        end
      end
      PRE: begin
        // Idempotent: once negated xr is non-negative, so extra PRE cycles do nothing.
        if (xr[W+1]) begin
          xr_n   = -xr;
          yr_n   = -yr;
          flip_n = 1'b1;
        end
        if (cnt == 4'd0) state_n = ITER;
      end
      ITER: begin
        if (!yr[W+1]) begin
          xr_n = xr + ys;
          yr_n = yr - xs;
        end else begin
          xr_n = xr - ys;
          yr_n = yr + xs;
        end
        for (int k = 0; k < ITERS; k++) begin
          if (cnt == 4'(k)) dir_n[k] = ~yr[W+1];
        end
        if (cnt == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
          state_n = COMP;
`else
          state_n = DONE;
`endif
        end
      end
`ifdef CORDIC_GAIN_COMP_EN
      COMP: begin
        xr_n    = (xr >>> 1) + (xr >>> 3) - (xr >>> 6) - (xr >>> 9);
        state_n = DONE;
      end
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Results are captured on the edge entering DONE so they are valid with the done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      xr       <= '0;
      yr       <= '0;
      dir_r    <= '0;
      flip_r   <= 1'b0;
      cnt_en   <= 1'b0;
      mag_out  <= '0;
      dir_out  <= '0;
      flip_out <= 1'b0;
    end else begin
      state  <= state_n;
      xr     <= xr_n;
      yr     <= yr_n;
      dir_r  <= dir_n;
      flip_r <= flip_n;
      cnt_en <= (state_n == ITER);
      if (state_n == DONE) begin
        mag_out  <= xr_n;
        dir_out  <= dir_n;
        flip_out <= flip_n;
      end
    end
  end

endmodule

// File: tb/tb_cordic_vec_ctrl.sv
// Directed self-checking bench for cordic_vec_ctrl with a behavioural iteration counter.
// Expected values follow CORDIC_GAIN_COMP_EN when defined.
module tb_cordic_vec_ctrl;

  localparam int W     = 16;
  localparam int ITERS = 12;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [17:0] MAG_A = 18'd5004;
  localparam logic [17:0] MAG_B = 18'd3004;
  localparam int LAT = ITERS + 3;
  localparam int II  = ITERS + 4;
`else
  localparam logic [17:0] MAG_A = 18'd8238;
  localparam logic [17:0] MAG_B = 18'd4944;
  localparam int LAT = ITERS + 2;
  localparam int II  = ITERS + 3;
`endif
  localparam logic [11:0] DIR_A = 12'h0D3;
  localparam logic [11:0] DIR_B = 12'h0D1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_in = '0;
  logic [3:0] cnt;
  logic [3:0] cnt_q = '0;
  logic cnt_hold = 1'b0;
  logic cnt_en, busy, done, flip_out;
  logic signed [W+1:0] mag_out;
  logic [ITERS-1:0] dir_out;

  int checks = 0;
  int failures = 0;

  cordic_vec_ctrl #(.W(W), .ITERS(ITERS)) dut (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .cnt(cnt), .cnt_en(cnt_en), .busy(busy), .done(done),
    .mag_out(mag_out), .dir_out(dir_out), .flip_out(flip_out)
  );

  always #5 clk = ~clk;

  // Shared iteration counter: counts while enabled, clears on the first idle cycle.
  always @(posedge clk) begin
    if (cnt_en) cnt_q <= cnt_q + 4'd1;
    else        cnt_q <= 4'd0;
  end
  assign cnt = cnt_hold ? 4'd5 : cnt_q;

  // Launches one operation (start in cycle 0) and records timing and results.
  task automatic run_op(input logic signed [W-1:0] xv, input logic signed [W-1:0] yv, input int hold,
                        output int done_cyc, output int en_first, output int en_last, output int en_cnt,
                        output logic [17:0] mag, output logic [11:0] dir, output logic flip);
    done_cyc = -1; en_first = -1; en_last = -1; en_cnt = 0; mag = '0; dir = '0; flip = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; x_in = xv; y_in = yv; cnt_hold = (hold > 0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 60; c++) begin
      cnt_hold = (c <= hold);
      @(negedge clk);
      if (cnt_en) begin
        if (en_first < 0) en_first = c;
        en_last = c;
        en_cnt++;
      end
      if (done) begin
        done_cyc = c; mag = mag_out; dir = dir_out; flip = flip_out;
        break;
      end
      @(posedge clk); #1;
    end
    cnt_hold = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    checks++; if (cnt_en !== 1'b0) begin failures++; $display("[TB] FAIL reset_cnt_en: got %b expected 0", cnt_en); end
    checks++; if (mag_out !== '0) begin failures++; $display("[TB] FAIL reset_mag: got %0d expected 0", mag_out); end
    checks++; if (dir_out !== '0) begin failures++; $display("[TB] FAIL reset_dir: got %h expected 0", dir_out); end
    checks++; if (flip_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_flip: got %b expected 0", flip_out); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_main();
    int dc, ef, el, ec; logic [17:0] m; logic [11:0] d; logic f;
    run_op(16'sd3000, 16'sd4000, 0, dc, ef, el, ec, m, d, f);
    checks++; if (dc !== LAT) begin failures++; $display("[TB] FAIL main_done_cycle: got %0d expected %0d", dc, LAT); end
    checks++; if (ef !== 2) begin failures++; $display("[TB] FAIL main_en_first: got %0d expected 2", ef); end
    checks++; if (el !== ITERS + 1) begin failures++; $display("[TB] FAIL main_en_last: got %0d expected %0d", el, ITERS + 1); end
    checks++; if (ec !== ITERS) begin failures++; $display("[TB] FAIL main_en_count: got %0d expected %0d", ec, ITERS); end
    checks++; if (m !== MAG_A) begin failures++; $display("[TB] FAIL main_mag: got %0d expected %0d", m, MAG_A); end
    checks++; if (d !== DIR_A) begin failures++; $display("[TB] FAIL main_dir: got %h expected %h", d, DIR_A); end
    checks++; if (f !== 1'b0) begin failures++; $display("[TB] FAIL main_flip: got %b expected 0", f); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("[TB] FAIL main_done_width: got %b expected 0", done); end
    checks++; if (mag_out !== MAG_A) begin failures++; $display("[TB] FAIL main_mag_hold: got %0d expected %0d", mag_out, MAG_A); end
  endtask

  task automatic test_flip();
    int dc, ef, el, ec; logic [17:0] m; logic [11:0] d; logic f;
    run_op(-16'sd3000, 16'sd0, 0, dc, ef, el, ec, m, d, f);
    checks++; if (m !== MAG_B) begin failures++; $display("[TB] FAIL flip_mag: got %0d expected %0d", m, MAG_B); end
    checks++; if (d !== DIR_B) begin failures++; $display("[TB] FAIL flip_dir: got %h expected %h", d, DIR_B); end
    checks++; if (f !== 1'b1) begin failures++; $display("[TB] FAIL flip_flag: got %b expected 1", f); end
    run_op(-16'sd3000, -16'sd4000, 0, dc, ef, el, ec, m, d, f);
    checks++; if (m !== MAG_A) begin failures++; $display("[TB] FAIL flip2_mag: got %0d expected %0d", m, MAG_A); end
    checks++; if (d !== DIR_A) begin failures++; $display("[TB] FAIL flip2_dir: got %h expected %h", d, DIR_A); end
    checks++; if (f !== 1'b1) begin failures++; $display("[TB] FAIL flip2_flag: got %b expected 1", f); end
  endtask

  task automatic test_zero();
    int dc, ef, el, ec; logic [17:0] m; logic [11:0] d; logic f;
    run_op(16'sd0, 16'sd0, 0, dc, ef, el, ec, m, d, f);
    checks++; if (m !== 18'd0) begin failures++; $display("[TB] FAIL zero_mag: got %0d expected 0", m); end
    checks++; if (d !== 12'hFFF) begin failures++; $display("[TB] FAIL zero_dir: got %h expected fff", d); end
    checks++; if (f !== 1'b0) begin failures++; $display("[TB] FAIL zero_flip: got %b expected 0", f); end
    checks++; if (dc !== LAT) begin failures++; $display("[TB] FAIL zero_done_cycle: got %0d expected %0d", dc, LAT); end
  endtask

  task automatic test_cnt_hold();
    int dc, ef, el, ec; logic [17:0] m; logic [11:0] d; logic f;
    run_op(16'sd3000, 16'sd4000, 3, dc, ef, el, ec, m, d, f);
    checks++; if (dc !== LAT + 3) begin failures++; $display("[TB] FAIL hold_done_cycle: got %0d expected %0d", dc, LAT + 3); end
    checks++; if (ef !== 5) begin failures++; $display("[TB] FAIL hold_en_first: got %0d expected 5", ef); end
    checks++; if (el !== ITERS + 4) begin failures++; $display("[TB] FAIL hold_en_last: got %0d expected %0d", el, ITERS + 4); end
    checks++; if (m !== MAG_A) begin failures++; $display("[TB] FAIL hold_mag: got %0d expected %0d", m, MAG_A); end
    checks++; if (d !== DIR_A) begin failures++; $display("[TB] FAIL hold_dir: got %h expected %h", d, DIR_A); end
  endtask

  task automatic test_reset_mid();
    int dc, ef, el, ec, dones; logic [17:0] m; logic [11:0] d; logic f;
    @(posedge clk); #1;
    start = 1'b1; x_in = 16'sd3000; y_in = 16'sd4000;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    start = 1'b1; x_in = -16'sd3000; y_in = 16'sd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    checks++; if (cnt_en !== 1'b1) begin failures++; $display("[TB] FAIL midstart_cnt_en: got %b expected 1", cnt_en); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL midstart_busy: got %b expected 1", busy); end
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checks++; if (cnt_en !== 1'b0) begin failures++; $display("[TB] FAIL midrst_cnt_en: got %b expected 0", cnt_en); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", busy); end
    checks++; if (mag_out !== '0) begin failures++; $display("[TB] FAIL midrst_mag: got %0d expected 0", mag_out); end
    checks++; if (dir_out !== '0) begin failures++; $display("[TB] FAIL midrst_dir: got %h expected 0", dir_out); end
    checks++; if (flip_out !== 1'b0) begin failures++; $display("[TB] FAIL midrst_flip: got %b expected 0", flip_out); end
    @(posedge clk); #1;
    reset = 1'b1;
    dones = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dones++;
    end
    checks++; if (dones !== 0) begin failures++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", dones); end
    run_op(16'sd3000, 16'sd4000, 0, dc, ef, el, ec, m, d, f);
    checks++; if (dc !== LAT) begin failures++; $display("[TB] FAIL after_rst_done_cycle: got %0d expected %0d", dc, LAT); end
    checks++; if (m !== MAG_A) begin failures++; $display("[TB] FAIL after_rst_mag: got %0d expected %0d", m, MAG_A); end
  endtask

  task automatic test_back_to_back();
    int rises[$];
    int high_cycles, bad_mag;
    logic prev;
    high_cycles = 0; bad_mag = 0; prev = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; x_in = 16'sd3000; y_in = 16'sd4000;
    for (int c = 0; c <= LAT + 2 * II + 3; c++) begin
      @(negedge clk);
      if (done) begin
        high_cycles++;
        if (!prev) rises.push_back(c);
        if (mag_out !== MAG_A) bad_mag++;
      end
      prev = done;
      @(posedge clk); #1;
    end
    start = 1'b0;
    repeat (II + 5) @(posedge clk);
    checks++; if (rises.size() !== 3) begin failures++; $display("[TB] FAIL b2b_pulses: got %0d expected 3", rises.size()); end
    checks++; if (high_cycles !== 3) begin failures++; $display("[TB] FAIL b2b_width: got %0d high cycles expected 3", high_cycles); end
    checks++; if (bad_mag !== 0) begin failures++; $display("[TB] FAIL b2b_mag: got %0d bad results expected 0", bad_mag); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= rises.size()) begin
        failures++; $display("[TB] FAIL b2b_rise%0d: got none expected %0d", i, LAT + i * II);
      end else if (rises[i] !== LAT + i * II) begin
        failures++; $display("[TB] FAIL b2b_rise%0d: got %0d expected %0d", i, rises[i], LAT + i * II);
      end
    end
  endtask

  initial begin
    test_reset();
    test_main();
    test_flip();
    test_zero();
    test_cnt_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
